// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-ported memory between the fetch port and the data port.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch in after STREAK_MAX back-to-back data grants.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          if_stall,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [2:0]    d_ctrl,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          d_stall,

    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [2:0]    m_ctrl,
    input  logic          m_ready,
    input  logic          m_rvalid,
    input  logic [DW-1:0] m_rdata,

    output logic          owner,
    output logic          busy
);

    // state  | meaning
    // IDLE   | no transaction, arbitrate between ports
    // ISSUE  | m_req held, waiting for m_ready
    // WAIT   | request accepted, waiting for m_rvalid
    // RESP   | owner's valid pulses for this cycle only
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        state_q;
    logic          m_req_q;
    logic          m_we_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
    logic [2:0]    m_ctrl_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          if_valid_q;
    logic          d_valid_q;
    logic          owner_q;

    logic          grant_data_d;
    logic          grant_fetch_d;
    logic          fetch_forced;
    logic          complete_d;
    logic [DW-1:0] rsp_data_d;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [2:0] STREAK_LIM = 3'(STREAK_MAX);

    logic [2:0] streak_q;
    logic [2:0] streak_d;

    assign fetch_forced = if_req && (streak_q >= STREAK_LIM);

    always_comb begin
        streak_d = streak_q;
        if (!if_req || grant_fetch_d) begin
            streak_d = 3'd0;
        end else if (grant_data_d && (streak_q < STREAK_LIM)) begin
            streak_d = streak_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= 3'd0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    logic unused_streak_max;

    assign unused_streak_max = |STREAK_MAX;
    assign fetch_forced      = 1'b0;
`endif

    always_comb begin
        grant_data_d  = 1'b0;
        grant_fetch_d = 1'b0;
        if (state_q == S_IDLE) begin
            if (d_req && !fetch_forced) begin
                grant_data_d = 1'b1;
            end else if (if_req) begin
                grant_fetch_d = 1'b1;
            end
        end
    end

    // A response may arrive in the same cycle the request is accepted.
    assign complete_d = ((state_q == S_ISSUE) && m_ready && m_rvalid) ||
                        ((state_q == S_WAIT) && m_rvalid);

    // Store acknowledgements carry no data back to the pipeline.
    assign rsp_data_d = m_we_q ? '0 : m_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_ctrl_q   <= 3'b000;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            owner_q    <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;

            if (complete_d) begin
                if (owner_q) begin
                    d_valid_q <= 1'b1;
                    d_rdata_q <= rsp_data_d;
                end else begin
                    if_valid_q <= 1'b1;
                    if_rdata_q <= rsp_data_d;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (grant_data_d) begin
                        owner_q   <= 1'b1;
                        m_req_q   <= 1'b1;
                        m_we_q    <= d_we;
                        m_addr_q  <= d_addr;
                        m_wdata_q <= d_wdata;
                        m_ctrl_q  <= d_ctrl;
                        state_q   <= S_ISSUE;
                    end else if (grant_fetch_d) begin
                        owner_q   <= 1'b0;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= if_addr;
                        m_wdata_q <= '0;
                        m_ctrl_q  <= 3'b000;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (m_ready) begin
                        m_req_q <= 1'b0;
                        state_q <= m_rvalid ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (m_rvalid) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_ctrl   = m_ctrl_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_valid = if_valid_q;
    assign d_valid  = d_valid_q;
    assign owner    = owner_q;
    assign busy     = (state_q != S_IDLE);

    assign if_stall = if_req & ~if_valid_q;
    assign d_stall  = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          if_stall;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [2:0]    d_ctrl;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          d_stall;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [2:0]    m_ctrl;
    logic          m_ready;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          owner;
    logic          busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STREAK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ctrl(d_ctrl), .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ctrl(m_ctrl), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .owner(owner), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fall();
        @(negedge clk);
    endtask

    initial begin
        int grants;
        logic [4:0] own_seq;
        logic [4:0] own_exp;

        rst = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0;
        d_addr = '0; d_wdata = '0; d_ctrl = '0;
        m_ready = 0; m_rvalid = 0; m_rdata = '0;
        fall(); fall();
        chk("rst_m_req", {31'd0, m_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        rst = 1'b1;

        // 1: reset in the middle of a pending load
        fall();
        d_req = 1; d_we = 0; d_addr = 32'h40; d_ctrl = 3'b010;
        fall();
        chk("t1_m_req", {31'd0, m_req}, 32'd1);
        chk("t1_owner", {31'd0, owner}, 32'd1);
        m_ready = 1;
        fall();
        m_ready = 0;
        chk("t1_wait_busy", {31'd0, busy}, 32'd1);
        chk("t1_wait_m_req", {31'd0, m_req}, 32'd0);
        rst = 1'b0;
        #1;
        chk("t1_rst_busy", {31'd0, busy}, 32'd0);
        chk("t1_rst_m_addr", m_addr, 32'd0);
        chk("t1_rst_m_ctrl", {29'd0, m_ctrl}, 32'd0);
        chk("t1_rst_owner", {31'd0, owner}, 32'd0);
        d_req = 0; d_addr = '0; d_ctrl = '0;
        fall();
        rst = 1'b1; m_rvalid = 1; m_rdata = 32'hCAFEF00D;
        fall();
        chk("t1_late_d_valid", {31'd0, d_valid}, 32'd0);
        chk("t1_late_busy", {31'd0, busy}, 32'd0);
        chk("t1_late_d_rdata", d_rdata, 32'd0);
        m_rvalid = 0;

        // 2: fetch alone, zero-wait memory
        fall();
        if_req = 1; if_addr = 32'h80;
        fall();
        chk("t2_m_req", {31'd0, m_req}, 32'd1);
        chk("t2_m_addr", m_addr, 32'h80);
        chk("t2_m_we", {31'd0, m_we}, 32'd0);
        chk("t2_m_ctrl", {29'd0, m_ctrl}, 32'd0);
        chk("t2_if_stall", {31'd0, if_stall}, 32'd1);
        m_ready = 1; m_rvalid = 1; m_rdata = 32'h00500093;
        fall();
        chk("t2_if_valid", {31'd0, if_valid}, 32'd1);
        chk("t2_if_rdata", if_rdata, 32'h00500093);
        chk("t2_if_stall_off", {31'd0, if_stall}, 32'd0);
        chk("t2_m_req_off", {31'd0, m_req}, 32'd0);
        m_ready = 0; m_rvalid = 0; if_req = 0;
        fall();
        chk("t2_if_valid_off", {31'd0, if_valid}, 32'd0);
        chk("t2_idle", {31'd0, busy}, 32'd0);

        // 3: fetch and store together, store goes first
        if_req = 1; if_addr = 32'h100;
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF; d_ctrl = 3'b010;
        fall();
        chk("t3_owner", {31'd0, owner}, 32'd1);
        chk("t3_m_we", {31'd0, m_we}, 32'd1);
        chk("t3_m_addr", m_addr, 32'h10);
        chk("t3_m_wdata", m_wdata, 32'hDEADBEEF);
        chk("t3_m_ctrl", {29'd0, m_ctrl}, 32'd2);
        chk("t3_if_stall_a", {31'd0, if_stall}, 32'd1);
        m_ready = 1;
        fall();
        chk("t3_if_stall_b", {31'd0, if_stall}, 32'd1);
        m_ready = 0; m_rvalid = 1; m_rdata = 32'hFFFFFFFF;
        fall();
        chk("t3_d_valid", {31'd0, d_valid}, 32'd1);
        chk("t3_d_rdata", d_rdata, 32'd0);
        chk("t3_d_stall", {31'd0, d_stall}, 32'd0);
        chk("t3_if_stall_c", {31'd0, if_stall}, 32'd1);
        chk("t3_if_valid_no", {31'd0, if_valid}, 32'd0);
        m_rvalid = 0; d_req = 0; d_we = 0;
        fall();
        chk("t3_idle_m_req", {31'd0, m_req}, 32'd0);
        chk("t3_d_valid_off", {31'd0, d_valid}, 32'd0);
        chk("t3_if_stall_d", {31'd0, if_stall}, 32'd1);
        fall();
        chk("t3_fetch_m_req", {31'd0, m_req}, 32'd1);
        chk("t3_fetch_owner", {31'd0, owner}, 32'd0);
        chk("t3_fetch_addr", m_addr, 32'h100);
        chk("t3_fetch_we", {31'd0, m_we}, 32'd0);
        chk("t3_fetch_ctrl", {29'd0, m_ctrl}, 32'd0);
        m_ready = 1; m_rvalid = 1; m_rdata = 32'hA5A5A5A5;
        fall();
        chk("t3_if_valid", {31'd0, if_valid}, 32'd1);
        chk("t3_if_rdata", if_rdata, 32'hA5A5A5A5);
        chk("t3_d_rdata_held", d_rdata, 32'd0);
        m_ready = 0; m_rvalid = 0; if_req = 0;
        fall();

        // 4: load with slow accept and slow response
        d_req = 1; d_we = 0; d_addr = 32'h200; d_ctrl = 3'b100;
        fall();
        chk("t4_m_req_1", {31'd0, m_req}, 32'd1);
        chk("t4_m_addr_1", m_addr, 32'h200);
        fall();
        chk("t4_m_req_2", {31'd0, m_req}, 32'd1);
        chk("t4_m_addr_2", m_addr, 32'h200);
        fall();
        chk("t4_m_req_3", {31'd0, m_req}, 32'd1);
        chk("t4_m_addr_3", m_addr, 32'h200);
        chk("t4_m_ctrl", {29'd0, m_ctrl}, 32'd4);
        m_ready = 1;
        fall();
        m_ready = 0;
        chk("t4_m_req_off", {31'd0, m_req}, 32'd0);
        chk("t4_d_stall_a", {31'd0, d_stall}, 32'd1);
        fall();
        chk("t4_d_valid_early", {31'd0, d_valid}, 32'd0);
        fall();
        m_rvalid = 1; m_rdata = 32'h12345678;
        fall();
        chk("t4_d_valid", {31'd0, d_valid}, 32'd1);
        chk("t4_d_rdata", d_rdata, 32'h12345678);
        m_rvalid = 0; d_req = 0;
        fall();
        chk("t4_d_valid_off", {31'd0, d_valid}, 32'd0);
        chk("t4_d_rdata_held", d_rdata, 32'h12345678);

        // 5: stray response while idle
        m_rvalid = 1; m_rdata = 32'h0BAD0BAD;
        fall();
        fall();
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_d_valid", {31'd0, d_valid}, 32'd0);
        chk("t5_if_valid", {31'd0, if_valid}, 32'd0);
        chk("t5_d_rdata", d_rdata, 32'h12345678);
        chk("t5_if_rdata", if_rdata, 32'hA5A5A5A5);
        m_rvalid = 0;
        fall();

        // 6: both ports request continuously; record owner of each grant
        d_req = 1; d_we = 0; d_addr = 32'h300; d_ctrl = 3'b010;
        if_req = 1; if_addr = 32'h400;
        grants = 0;
        own_seq = '0;
        for (int c = 0; c < 60 && grants < 5; c++) begin
            fall();
            if (m_req) begin
                own_seq[grants] = owner;
                grants++;
            end
            m_ready = m_req; m_rvalid = m_req; m_rdata = 32'h1111;
        end
        chk("t6_grant_count", grants, 32'd5);
`ifdef ARB_STARVE_GUARD_EN
        own_exp = 5'b01111;
`else
        own_exp = 5'b11111;
`endif
        chk("t6_owner_seq", {27'd0, own_seq}, {27'd0, own_exp});
        d_req = 0; if_req = 0;
        for (int c = 0; c < 4; c++) begin
            fall();
            m_ready = m_req; m_rvalid = m_req;
        end
        m_ready = 0; m_rvalid = 0;
        fall();
        chk("t6_drained", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
